// File: rtl/rgb_led_arbiter.sv
// Round-robin owner arbitration for the shared RGB LED driver, with minimum hold time.
// Define RGB_ARB_PWM_EN to gate the LED outputs with a global brightness PWM.
module rgb_led_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 12000000,
   parameter int CNT_W       = 24,
   parameter int PWM_W       = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [3*NUM_REQ-1:0]   color,
   input  logic [PWM_W-1:0]       brightness,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   led_r,
   output logic                   led_g,
   output logic                   led_b
);

   localparam int OW = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [OW-1:0]    owner;
   logic [OW-1:0]    last_owner;
   logic [OW-1:0]    base;
   logic [OW-1:0]    win;
   logic [OW-1:0]    idx;
   logic             found;
   logic             expire;
   logic [2:0]       own_color;
   logic             pwm_on;

   assign expire    = (state == HOLD) && (hold_cnt == HOLD_LAST);
   // At expiry the current owner becomes the rotation origin, so it is searched last
   assign base      = expire ? owner : last_owner;
   assign own_color = color[3*int'(owner) +: 3];

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = OW'((int'(base) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

`ifdef RGB_ARB_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) pwm_cnt <= '0;
      else        pwm_cnt <= pwm_cnt + PWM_W'(1);
   end

   assign pwm_on = (pwm_cnt < brightness);
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign pwm_on = 1'b1;
`endif

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         owner      <= '0;
         last_owner <= OW'(NUM_REQ - 1);
         grant      <= '0;
         busy       <= 1'b0;
         led_r      <= 1'b0;
         led_g      <= 1'b0;
         led_b      <= 1'b0;
      end else begin
         led_r <= busy & own_color[2] & pwm_on;
         led_g <= busy & own_color[1] & pwm_on;
         led_b <= busy & own_color[0] & pwm_on;
         unique case (state)
            IDLE: begin
               if (found) begin
                  state    <= HOLD;
                  owner    <= win;
                  grant    <= NUM_REQ'(1) << win;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            HOLD: begin
               if (expire) begin
                  last_owner <= owner;
                  hold_cnt   <= '0;
                  if (found) begin
                     owner <= win;
                     grant <= NUM_REQ'(1) << win;
                  end else begin
                     state <= IDLE;
                     grant <= '0;
                     busy  <= 1'b0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: vector table, corner sequences, random vs. model.
// Works with or without RGB_ARB_PWM_EN defined.
module tb_rgb_led_arbiter;

   localparam int N  = 4;
   localparam int H  = 4;
   localparam int PW = 8;

   logic            clk_in = 1'b0;
   logic            rst_n  = 1'b0;
   logic [N-1:0]    req    = '0;
   logic [3*N-1:0]  color  = '0;
   logic [PW-1:0]   brightness = 8'd255;
   logic [N-1:0]    grant;
   logic            busy;
   logic            led_r;
   logic            led_g;
   logic            led_b;

   int checks   = 0;
   int failures = 0;

   rgb_led_arbiter #(
      .NUM_REQ(N), .HOLD_CYCLES(H), .CNT_W(8), .PWM_W(PW)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .req(req), .color(color),
      .brightness(brightness), .grant(grant), .busy(busy),
      .led_r(led_r), .led_g(led_g), .led_b(led_b)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic hard_reset();
      @(negedge clk_in);
      rst_n = 1'b0;
      @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   // Reference model: owner index (-1 idle), cycles held, last owner
   int         m_cur;
   int         m_cnt;
   int         m_last;
   int         m_pwm;
   logic [2:0] m_led;

   function automatic int pick(input logic [N-1:0] r, input int from);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (from + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_cur = -1; m_cnt = 0; m_last = N - 1; m_pwm = 0; m_led = '0;
   endtask

   task automatic m_edge();
      logic [2:0] c;
      logic       on;
      on = 1'b1;
`ifdef RGB_ARB_PWM_EN
      on = (m_pwm < int'(brightness));
      m_pwm = (m_pwm + 1) % (1 << PW);
`endif
      c = (m_cur >= 0) ? color[3*m_cur +: 3] : 3'b000;
      m_led = on ? c : 3'b000;
      if (m_cur < 0) begin
         m_cur = pick(req, m_last);
         m_cnt = 0;
      end else if (m_cnt == H - 1) begin
         m_last = m_cur;
         m_cur  = pick(req, m_last);
         m_cnt  = 0;
      end else begin
         m_cnt++;
      end
   endtask

   typedef struct {
      logic [3:0]  rq;
      logic [11:0] col;
      logic [3:0]  g;
      logic        b;
      logic [2:0]  led;
   } vec_t;

   vec_t       tbl [12];
   logic [3:0] seq3 [4];

   initial begin
      tbl[0]  = '{4'b0100, 12'h140, 4'b0100, 1'b1, 3'b000};
      tbl[1]  = '{4'b0000, 12'h140, 4'b0100, 1'b1, 3'b101};
      tbl[2]  = '{4'b0000, 12'h140, 4'b0100, 1'b1, 3'b101};
      tbl[3]  = '{4'b0000, 12'h000, 4'b0100, 1'b1, 3'b000};
      tbl[4]  = '{4'b0000, 12'h1c0, 4'b0000, 1'b0, 3'b111};
      tbl[5]  = '{4'b0000, 12'h1c0, 4'b0000, 1'b0, 3'b000};
      tbl[6]  = '{4'b0001, 12'h002, 4'b0001, 1'b1, 3'b000};
      tbl[7]  = '{4'b0000, 12'h002, 4'b0001, 1'b1, 3'b010};
      tbl[8]  = '{4'b0000, 12'h002, 4'b0001, 1'b1, 3'b010};
      tbl[9]  = '{4'b0000, 12'h002, 4'b0001, 1'b1, 3'b010};
      tbl[10] = '{4'b0000, 12'h002, 4'b0000, 1'b0, 3'b010};
      tbl[11] = '{4'b0000, 12'h002, 4'b0000, 1'b0, 3'b000};
      seq3[0] = 4'b0001; seq3[1] = 4'b0010;
      seq3[2] = 4'b1000; seq3[3] = 4'b0001;

      // Reset behaviour with all requesters active
      req = 4'b1111;
      @(negedge clk_in);
      rst_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_leds", {led_r, led_g, led_b}, 0);
      tick();
      chk("rst_edge_grant", grant, 0);
      @(negedge clk_in);
      rst_n = 1'b1;
      #1;
      chk("post_rel_grant", grant, 0);
      chk("post_rel_busy", busy, 0);
      tick();
      chk("first_arb", grant, 4'b0001);

      // Vector table: single owner, LED latency, drop to idle
      req = '0;
      hard_reset();
      for (int i = 0; i < 12; i++) begin
         req   = tbl[i].rq;
         color = tbl[i].col;
         tick();
         chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
         chk($sformatf("tbl%0d_led", i), {led_r, led_g, led_b}, tbl[i].led);
      end

      // Rotation with skipped requester, exactly H cycles each
      req   = 4'b1011;
      color = '0;
      hard_reset();
      for (int c = 0; c < 16; c++) begin
         tick();
         chk($sformatf("rot_c%0d", c), grant, seq3[c/4]);
         chk("rot_onehot", $onehot0(grant), 1);
      end

      // Async reset in the second hold cycle of owner 1
      req = 4'b1010;
      color = 12'hfff;
      hard_reset();
      tick();
      chk("r6_grant0", grant, 4'b0010);
      tick();
      rst_n = 1'b0;
      #1;
      chk("r6_async_grant", grant, 0);
      chk("r6_async_busy", busy, 0);
      chk("r6_async_leds", {led_r, led_g, led_b}, 0);
      @(negedge clk_in);
      rst_n = 1'b1;
      tick();
      chk("r6_regrant", grant, 4'b0010);

`ifdef RGB_ARB_PWM_EN
      begin
         int on_cnt;
         req = 4'b0001;
         color = 12'h004;
         brightness = 8'd64;
         hard_reset();
         tick();
         tick();
         on_cnt = 0;
         for (int c = 0; c < 256; c++) begin
            tick();
            on_cnt += int'(led_r);
         end
         chk("pwm_64", on_cnt, 64);
         brightness = 8'd0;
         on_cnt = 0;
         for (int c = 0; c < 256; c++) begin
            tick();
            on_cnt += int'(led_r);
         end
         chk("pwm_0", on_cnt, 0);
      end
`endif

      // Random traffic against the reference model
      req = '0;
      brightness = 8'd255;
      hard_reset();
      m_reset();
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < N; b++)
            req[b] = ($urandom_range(0, 9) < 3);
         color = 12'($urandom);
`ifdef RGB_ARB_PWM_EN
         brightness = 8'($urandom);
`endif
         m_edge();
         tick();
         chk("rnd_grant", grant, (m_cur < 0) ? 0 : (1 << m_cur));
         chk("rnd_busy", busy, (m_cur >= 0) ? 1 : 0);
         chk("rnd_led", {led_r, led_g, led_b}, m_led);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
